case_distribute: RTL and testbench
==================================

# case_distribute

Registered 1-to-6 demultiplexer. It is the sink-side counterpart of the 6-to-1 case-select mux: one 4-bit source stream is routed to one of six output channels. Each channel has a one-entry holding register with a valid/ready handshake. Channel selection comes either from an explicit `in_sel` or from an internal round-robin pointer. Out-of-range selects are dropped and counted.

## Interface
Parameters:
- `WIDTH`, 4: data width of input and of every output channel.
- `NCH`, 6: number of output channels; legal select values are 0..NCH-1.
- `CNT_W`, 8: width of the saturating drop counter.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset is asynchronous and active-low.
- `auto`, input, 1: 1 = round-robin select; 0 = use `in_sel`.
- `in_valid`, input, 1: source beat present.
- `in_ready`, output, 1: block accepts the beat this cycle (combinational).
- `in_sel`, input, 3: target channel when `auto`=0.
- `in_data`, input, WIDTH: beat payload.
- `out_data0`..`out_data5`, output, WIDTH each: channel holding registers.
- `out_valid`, output, NCH: bit k = channel k holds a beat.
- `out_ready`, input, NCH: bit k = channel k sink consumes this cycle.
- `rr_ptr`, output, 3: current round-robin pointer.
- `drop_count`, output, CNT_W: number of dropped beats, saturating.
- `sel_err`, output, 1: sticky flag, set on the first drop.

## Operation
- Target `t` = `rr_ptr` if `auto`=1, else `in_sel`.
- Valid target (t < NCH): `in_ready` = !`out_valid[t]` || `out_ready[t]`.
- Invalid target (`in_sel` = 6 or 7, `auto`=0): `in_ready` = 1. The beat is discarded. `drop_count` increments unless it is at its maximum (255), where it holds. `sel_err` is set to 1 and stays set until reset. No channel changes state.
- Accept = `in_valid` && `in_ready`.
- On accept to a valid target: `out_data<t>` <= `in_data` and `out_valid[t]` <= 1.
- Drain: if `out_valid[k]` && `out_ready[k]` and channel k is not loaded this cycle, `out_valid[k]` <= 0. `out_data<k>` holds its last value.
- Simultaneous drain and load on the same channel: the new beat is loaded and `out_valid[k]` stays 1. This gives one beat per cycle per channel.
- Channels other than `t` drain independently in the same cycle.
- Round-robin pointer:
  - Advances only on an accepted beat while `auto`=1.
  - Sequence is 0,1,...,5,0 (wraps from NCH-1 to 0). It never takes the values 6 or 7.
  - Holds its value when `auto`=0. Switching `auto` does not reset it.
- `in_sel` is ignored while `auto`=1. When `auto`=1 the target is always valid, so no drops can occur.
- Reset mid-operation: all held beats are discarded immediately (asynchronous), regardless of `out_ready`.

## Timing
- Reset values: `out_valid`=0, `out_data0..5`=0, `rr_ptr`=0, `drop_count`=0, `sel_err`=0.
- `in_ready` is a combinational function of `auto`, `in_sel`, `rr_ptr`, `out_valid`, `out_ready`.
- There is no combinational path from `in_data` or `in_valid` to any output.
- Latency: a beat accepted at edge N appears on `out_data<t>` with `out_valid[t]`=1 after edge N, i.e. it is visible in cycle N+1.
- `drop_count` and `sel_err` update at the accepting edge.
- A channel with `out_valid`=1 and `out_ready`=0 back-pressures only beats targeting that channel.
- In auto mode, a stalled pointer target stalls the whole input (strict order, no skipping).
- Reset assertion takes effect asynchronously. Deassertion is sampled on the next `clk` rising edge; the first accept is possible on that edge.

## Test plan
1. **Reset.** Assert `rst_n`=0 mid-stream with channels 2 and 4 holding data.
   - Required: `out_valid`=000000, all `out_data`=0, `rr_ptr`=0, `drop_count`=0, `sel_err`=0 immediately, before any clock edge.
2. **Directed routing.** `auto`=0, `out_ready`=111111. Drive `in_sel`=0..5 with `in_data`=A..F, one beat per cycle.
   - Required: `out_dataK` = A+K one cycle after acceptance; a single `out_valid` bit is high each cycle; `in_ready`=1 throughout.
3. **Invalid select.** Send `in_sel`=7 then `in_sel`=6, each with `in_valid`=1.
   - Required: `in_ready`=1; `out_valid` unchanged; `drop_count`=2; `sel_err`=1.
   - Then send 300 invalid beats. Required: `drop_count`=255 (saturated).
4. **Back-pressure.** `out_ready[3]`=0. Send a beat to channel 3, then a second beat to channel 3, then a beat to channel 1.
   - Required: the second beat sees `in_ready`=0 and waits; channel 1 is unaffected once reached.
   - Raise `out_ready[3]`=1. Required: the second beat is accepted that cycle and `out_valid[3]` stays 1 with the new data.
5. **Round-robin wrap.** `auto`=1, `in_sel`=7, all ready. Send 8 beats 0..7.
   - Required: channels 0,1,2,3,4,5,0,1 receive beats 0..7; `rr_ptr` = 2 at the end; `drop_count`=0.
6. **Auto-mode stall.** `auto`=1, `rr_ptr`=2, `out_valid[2]`=1, `out_ready[2]`=0.
   - Required: `in_ready`=0 and `rr_ptr` holds at 2.
   - Toggle `auto`=0 with `in_sel`=4. Required: the beat is accepted to channel 4 and `rr_ptr` remains 2.

Source files
------------

// File: rtl/case_distribute.sv
// case_distribute: registered 1-to-NCH demux with per-channel one-entry holding registers,
// explicit or round-robin channel select, and a saturating count of out-of-range drops.
module case_distribute #(
    parameter int WIDTH = 4,
    parameter int NCH   = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             auto,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [WIDTH-1:0] out_data4,
    output logic [WIDTH-1:0] out_data5,
    output logic [NCH-1:0]   out_valid,
    input  logic [NCH-1:0]   out_ready,
    output logic [2:0]       rr_ptr,
    output logic [CNT_W-1:0] drop_count,
    output logic             sel_err
);
    logic [WIDTH-1:0] data [NCH];
    logic [2:0]       tgt;
    logic             tgt_ok;
    logic             accept;
    logic             drop;
    logic [NCH-1:0]   load;

    assign tgt      = auto ? rr_ptr : in_sel;
    assign tgt_ok   = int'(tgt) < NCH;
    // out-of-range targets are always accepted so the source never stalls on a bad select
    assign in_ready = tgt_ok ? (!out_valid[tgt] || out_ready[tgt]) : 1'b1;
    assign accept   = in_valid && in_ready;
    assign drop     = accept && !tgt_ok;
    assign load     = (accept && tgt_ok) ? NCH'(1) << tgt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= '0;
            rr_ptr     <= '0;
            drop_count <= '0;
            sel_err    <= 1'b0;
            for (int k = 0; k < NCH; k++) data[k] <= '0;
        end else begin
            out_valid <= load | (out_valid & ~out_ready);
            for (int k = 0; k < NCH; k++) if (load[k]) data[k] <= in_data;
            if (accept && auto) rr_ptr <= (int'(rr_ptr) == NCH - 1) ? '0 : rr_ptr + 3'd1;
            if (drop && drop_count != '1) drop_count <= drop_count + CNT_W'(1);
            sel_err <= sel_err | drop;
        end
    end

    assign out_data0 = data[0];
    assign out_data1 = data[1];
    assign out_data2 = data[2];
    assign out_data3 = data[3];
    assign out_data4 = data[4];
    assign out_data5 = data[5];
endmodule

// File: tb/tb_case_distribute.sv
// tb_case_distribute: directed plus random stimulus; per-channel expected-beat queues
// are filled by the driver and drained by a monitor whenever a channel is consumed.
module tb_case_distribute;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       auto = 0;
    logic       in_valid = 0;
    logic       in_ready;
    logic [2:0] in_sel = 0;
    logic [3:0] in_data = 0;
    logic [3:0] out_data0, out_data1, out_data2, out_data3, out_data4, out_data5;
    logic [5:0] out_valid;
    logic [5:0] out_ready = 0;
    logic [2:0] rr_ptr;
    logic [7:0] drop_count;
    logic       sel_err;

    int tests = 0;
    int fails = 0;

    logic [3:0] q [6][$];
    int m_rr = 0;
    int m_drop = 0;
    int m_err = 0;
    logic [3:0] od [6];

    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;
    assign od[4] = out_data4;
    assign od[5] = out_data5;

    case_distribute #(.WIDTH(4), .NCH(6), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .auto(auto), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data),
        .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2),
        .out_data3(out_data3), .out_data4(out_data4), .out_data5(out_data5),
        .out_valid(out_valid), .out_ready(out_ready), .rr_ptr(rr_ptr),
        .drop_count(drop_count), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int a, input int e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    // a held beat that is not yet consumed must be visible; a consumed beat must match the oldest expected
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("out_valid[%0d]", k), int'(out_valid[k]), int'(q[k].size() != 0));
                if (out_valid[k] && out_ready[k] && q[k].size() != 0) begin
                    logic [3:0] e;
                    e = q[k].pop_front();
                    chk($sformatf("out_data%0d", k), int'(od[k]), int'(e));
                end
            end
        end
    end

    // one source cycle: drive at posedge+1, check and update the model just after the negedge
    task automatic step(input bit a, input bit v, input bit [2:0] s, input bit [3:0] d, input bit [5:0] r);
        int t;
        bit er;
        auto = a; in_valid = v; in_sel = s; in_data = d; out_ready = r;
        @(negedge clk);
        #1;
        t = a ? m_rr : int'(s);
        er = (t >= 6) || (q[t].size() == 0) || r[t];
        chk("in_ready", int'(in_ready), int'(er));
        chk("rr_ptr", int'(rr_ptr), m_rr);
        chk("drop_count", int'(drop_count), m_drop);
        chk("sel_err", int'(sel_err), m_err);
        if (v && er) begin
            if (t >= 6) begin
                if (m_drop < 255) m_drop++;
                m_err = 1;
            end else begin
                q[t].push_back(d);
                if (a) m_rr = (m_rr + 1) % 6;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state();
        chk("rst out_valid", int'(out_valid), 0);
        for (int k = 0; k < 6; k++) chk($sformatf("rst out_data%0d", k), int'(od[k]), 0);
        chk("rst rr_ptr", int'(rr_ptr), 0);
        chk("rst drop_count", int'(drop_count), 0);
        chk("rst sel_err", int'(sel_err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state();
        rst_n = 1;
        @(posedge clk);
        #1;
        // directed routing
        for (int k = 0; k < 6; k++) step(0, 1, 3'(k), 4'(10 + k), 6'h3f);
        step(0, 0, 0, 0, 6'h3f);
        // invalid selects and saturation
        step(0, 1, 7, 4'h1, 6'h3f);
        step(0, 1, 6, 4'h2, 6'h3f);
        chk("drop_count after 2", int'(drop_count), 2);
        chk("sel_err after drop", int'(sel_err), 1);
        for (int i = 0; i < 300; i++) step(0, 1, 3'(6 + (i % 2)), 4'(i), 6'h3f);
        chk("drop_count saturated", int'(drop_count), 255);
        // back-pressure on channel 3
        step(0, 1, 3, 4'h5, 6'b110111);
        for (int i = 0; i < 3; i++) step(0, 1, 3, 4'h9, 6'b110111);
        step(0, 1, 1, 4'h7, 6'b110111);
        step(0, 1, 3, 4'h9, 6'h3f);
        chk("ch3 reloaded valid", int'(out_valid[3]), 1);
        chk("ch3 reloaded data", int'(out_data3), 9);
        step(0, 0, 0, 0, 6'h3f);
        // asynchronous reset with channels 2 and 4 holding
        step(0, 1, 2, 4'hc, 6'b101011);
        step(0, 1, 4, 4'hd, 6'b101011);
        in_valid = 0;
        #2;
        rst_n = 0;
        #1;
        chk_reset_state();
        for (int k = 0; k < 6; k++) q[k].delete();
        m_rr = 0; m_drop = 0; m_err = 0;
        rst_n = 1;
        @(posedge clk);
        #1;
        // round-robin wrap
        for (int i = 0; i < 8; i++) step(1, 1, 7, 4'(i), 6'h3f);
        chk("rr_ptr after wrap", int'(rr_ptr), 2);
        chk("drop_count in auto", int'(drop_count), 0);
        // auto-mode stall on channel 2, then a directed beat to channel 4
        step(0, 1, 2, 4'h3, 6'b111011);
        step(1, 1, 7, 4'h8, 6'b111011);
        step(1, 1, 7, 4'h8, 6'b111011);
        chk("rr_ptr stalled", int'(rr_ptr), 2);
        step(0, 1, 4, 4'h6, 6'b111011);
        chk("rr_ptr after directed", int'(rr_ptr), 2);
        chk("ch4 loaded", int'(out_data4), 6);
        // random traffic
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                 4'($urandom), 6'(~($urandom & $urandom)));
        repeat (3) step(0, 0, 0, 0, 6'h3f);
        for (int k = 0; k < 6; k++) chk($sformatf("drained ch%0d", k), q[k].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
